// File: rtl/seq_detector_param_pkg.sv
// Shared constants and elaboration-time helpers for the serial sequence detector.
// Patterns are MSB-first: bit WIDTH-1 is the first bit received.
package seq_det_pkg;

  localparam logic FOUND    = 1'b1;
  localparam logic NOTFOUND = 1'b0;

  // Longest prefix of pattern that is a suffix of (first len pattern bits, then b).
  function automatic int next_len(logic [15:0] pattern, int width, int len, logic b);
    int   best;
    int   idx;
    logic ok;
    logic sb;
    best = 0;
    for (int k = 1; k <= len + 1; k++) begin
      if (k <= width) begin
        ok = 1'b1;
        for (int i = 0; i < k; i++) begin
          idx = len + 1 - k + i;
          sb  = (idx == len) ? b : pattern[width-1-idx];
          if (sb != pattern[width-1-i]) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  // Longest proper prefix of the pattern that is also a suffix of it.
  function automatic int fail_len(logic [15:0] pattern, int width);
    int   best;
    logic ok;
    best = 0;
    for (int k = 1; k < width; k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++) begin
        if (pattern[width-1-i] != pattern[k-1-i]) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Serial bit stream in, match flag / statistics out.
// Both detector instances and the bench share this bundle.
interface seq_det_if #(
  parameter int WIDTH   = 4,
  parameter int COUNT_W = 8
);
  logic                           clr;
  logic                           x_valid;
  logic                           x;
  logic                           y;
  logic [COUNT_W-1:0]             match_count;
  logic [$clog2(WIDTH+1)-1:0]     depth;

  modport master (
    output clr, x_valid, x,
    input  y, match_count, depth
  );

  modport slave (
    input  clr, x_valid, x,
    output y, match_count, depth
  );
endinterface

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter: increments on en, sticks at all-ones, sync clear beats en.
// Result visible the cycle after the enabling edge; no backpressure.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised KMP serial sequence detector with valid qualifier, sync clear and match counter.
// Mealy y in the final-bit cycle, Moore y one cycle later; bits only consumed when x_valid=1.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] PATTERN = 4'b1101,
  parameter bit               MOORE   = 1'b0,
  parameter bit               OVERLAP = 1'b1,
  parameter int               COUNT_W = 8
) (
  input  logic      clk,
  input  logic      reset,
  seq_det_if.slave  bus
);

  localparam int               DW     = $clog2(WIDTH + 1);
  localparam int               NS     = 1 << DW;
  localparam logic [15:0]      PAT16  = 16'(PATTERN);
  localparam logic [DW-1:0]    LAST   = DW'(WIDTH - 1);
  localparam logic [DW-1:0]    FAIL_L = OVERLAP ? DW'(fail_len(PAT16, WIDTH)) : '0;

  logic [DW-1:0] len_q;
  logic [DW-1:0] len_safe;
  logic [DW-1:0] len_nxt;
  logic          match;
  logic [DW-1:0] nxt_tbl [NS][2];

  // Table covers every encodable state; unreachable ones behave like the empty prefix.
  for (genvar s = 0; s < NS; s++) begin : g_state
    for (genvar b = 0; b < 2; b++) begin : g_bit
      localparam int SRC = (s < WIDTH) ? s : 0;
      assign nxt_tbl[s][b] = DW'(next_len(PAT16, WIDTH, SRC, (b != 0)));
    end
  end

  always_comb begin
    len_safe = (len_q <= LAST) ? len_q : '0;
    match    = bus.x_valid && (len_safe == LAST) && (bus.x == PATTERN[0]);
    len_nxt  = match ? FAIL_L : nxt_tbl[len_safe][bus.x];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q <= '0;
    end else if (bus.clr) begin
      len_q <= '0;
    end else if (bus.x_valid) begin
      len_q <= len_nxt;
    end
  end

  if (MOORE) begin : g_moore
    logic y_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        y_q <= NOTFOUND;
      end else if (bus.clr) begin
        y_q <= NOTFOUND;
      end else if (bus.x_valid) begin
        y_q <= match ? FOUND : NOTFOUND;
      end
    end
    assign bus.y = y_q;
  end else begin : g_mealy
    assign bus.y = (match && !bus.clr) ? FOUND : NOTFOUND;
  end

  logic [COUNT_W-1:0] count_q;

  sat_counter #(.W(COUNT_W)) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.clr),
    .en    (match),
    .q     (count_q)
  );

  assign bus.match_count = count_q;
  assign bus.depth       = len_safe;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: two detectors (Mealy/overlap/8-bit count, Moore/no-overlap/2-bit count)
// share one stimulus stream and are checked against a bit-history reference model.
module tb_seq_detector_param;

  localparam int         W   = 4;
  localparam logic [3:0] PAT = 4'b1101;

  logic clk;
  logic reset;

  seq_det_if #(.WIDTH(W), .COUNT_W(8)) ifa ();
  seq_det_if #(.WIDTH(W), .COUNT_W(2)) ifb ();

  seq_detector_param #(.WIDTH(W), .PATTERN(PAT), .MOORE(1'b0), .OVERLAP(1'b1), .COUNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  seq_detector_param #(.WIDTH(W), .PATTERN(PAT), .MOORE(1'b1), .OVERLAP(1'b0), .COUNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    y_a;
    int    dep_a;
    int    cnt_a;
    int    y_b;
    int    dep_b;
    int    cnt_b;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model: raw history of accepted bits since the last restart, newest in bit 0.
  logic [31:0] hist [2];
  int          hlen [2];
  int          cnt  [2];
  int          cmax [2];
  int          yb;

  function automatic int depth_of(logic [31:0] h, int n);
    int d;
    d = 0;
    for (int k = 1; k < W; k++) begin
      if (k <= n && ((h & ((32'd1 << k) - 1)) == (32'(PAT) >> (W - k)))) d = k;
    end
    return d;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      hist[i] = '0;
      hlen[i] = 0;
      cnt[i]  = 0;
    end
    yb = 0;
  endtask

  task automatic step(input bit r, input bit c, input bit v, input bit xb, input string tag);
    exp_t        e;
    bit          m [2];
    logic [31:0] nh [2];
    int          nl [2];
    @(posedge clk);
    #1;
    reset = r;
    ifa.clr = c; ifa.x_valid = v; ifa.x = xb;
    ifb.clr = c; ifb.x_valid = v; ifb.x = xb;
    if (r) model_clear();
    for (int i = 0; i < 2; i++) begin
      nh[i] = (hist[i] << 1) | 32'(xb);
      nl[i] = hlen[i] + 1;
      m[i]  = !r && !c && v && (nl[i] >= W) && ((nh[i] & 32'hF) == 32'(PAT));
    end
    e.tag   = tag;
    e.y_a   = int'(m[0]);
    e.dep_a = depth_of(hist[0], hlen[0]);
    e.cnt_a = cnt[0];
    e.y_b   = yb;
    e.dep_b = depth_of(hist[1], hlen[1]);
    e.cnt_b = cnt[1];
    exp_q.push_back(e);
    if (!r) begin
      if (c) begin
        model_clear();
      end else if (v) begin
        for (int i = 0; i < 2; i++) begin
          if (m[i] && cnt[i] < cmax[i]) cnt[i] = cnt[i] + 1;
          if (m[i] && i == 1) begin
            hist[i] = '0;
            hlen[i] = 0;
          end else begin
            hist[i] = nh[i];
            hlen[i] = (nl[i] > 16) ? 16 : nl[i];
          end
        end
        yb = int'(m[1]);
      end
    end
  endtask

  task automatic bits(input logic [31:0] seq, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b0, 1'b1, seq[i], tag);
  endtask

  task automatic chk(input string tag, input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s/%s got %0d expected %0d at %0t", tag, name, act, req, $time);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.tag, "y_mealy",   int'(ifa.y),           e.y_a);
      chk(e.tag, "depth_a",   int'(ifa.depth),       e.dep_a);
      chk(e.tag, "count_a",   int'(ifa.match_count), e.cnt_a);
      chk(e.tag, "y_moore",   int'(ifb.y),           e.y_b);
      chk(e.tag, "depth_b",   int'(ifb.depth),       e.dep_b);
      chk(e.tag, "count_b",   int'(ifb.match_count), e.cnt_b);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cmax[0] = 255;
    cmax[1] = 3;
    model_clear();
    reset = 1'b1;
    ifa.clr = 1'b0; ifa.x_valid = 1'b0; ifa.x = 1'b0;
    ifb.clr = 1'b0; ifb.x_valid = 1'b0; ifb.x = 1'b0;

    step(1'b1, 1'b0, 1'b0, 1'b0, "reset");
    step(1'b1, 1'b0, 1'b1, 1'b1, "reset");
    step(1'b0, 1'b0, 1'b0, 1'b0, "release");

    bits(32'b110, 3, "rst_mid");
    step(1'b1, 1'b0, 1'b0, 1'b0, "rst_mid_pulse");
    step(1'b0, 1'b0, 1'b1, 1'b1, "rst_mid_after");
    step(1'b0, 1'b0, 1'b0, 1'b0, "rst_mid_depth");
    step(1'b0, 1'b1, 1'b0, 1'b0, "clr");

    bits(32'b1101, 4, "basic");
    step(1'b0, 1'b0, 1'b0, 1'b0, "basic_idle");
    step(1'b0, 1'b1, 1'b0, 1'b0, "clr");

    bits(32'b1101101, 7, "overlap");
    step(1'b0, 1'b0, 1'b0, 1'b0, "overlap_idle");
    step(1'b0, 1'b1, 1'b0, 1'b0, "clr");

    step(1'b0, 1'b0, 1'b1, 1'b1, "gaps");
    step(1'b0, 1'b0, 1'b0, 1'($urandom), "gaps");
    step(1'b0, 1'b0, 1'b1, 1'b1, "gaps");
    step(1'b0, 1'b0, 1'b0, 1'($urandom), "gaps");
    step(1'b0, 1'b0, 1'b0, 1'($urandom), "gaps");
    step(1'b0, 1'b0, 1'b1, 1'b0, "gaps");
    step(1'b0, 1'b0, 1'b1, 1'b1, "gaps");
    step(1'b0, 1'b0, 1'b0, 1'($urandom), "gaps_idle");
    step(1'b0, 1'b1, 1'b0, 1'b0, "clr");

    for (int g = 0; g < 5; g++) bits(32'b1101, 4, "saturate");
    step(1'b0, 1'b0, 1'b0, 1'b0, "saturate_idle");
    step(1'b0, 1'b1, 1'b0, 1'b0, "clr");

    bits(32'b110, 3, "clr_coll");
    step(1'b0, 1'b1, 1'b1, 1'b1, "clr_coll_edge");
    bits(32'b1101, 4, "clr_coll_after");
    step(1'b0, 1'b0, 1'b0, 1'b0, "clr_coll_idle");

    for (int n = 0; n < 1500; n++) begin
      step(($urandom % 200) == 0, ($urandom % 50) == 0, ($urandom % 4) != 0,
           1'($urandom), "random");
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, "drain");

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
